wb_port_arbiter: RTL and testbench

- Single-clock arbiter between N wb_port internal interfaces and the one SDRAM controller command/data interface.
- Grants ports round-robin and muxes each port's adr/dat/sel/we/acc to the controller.
- Routes the controller's ack only to the granted port; broadcasts returned address and data to all ports.
- Reassembles each completed 32-bit SDRAM write and broadcasts it on the bufw_* bus, so other ports' read buffers stay coherent.

---
 rtl/sdram_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/wb_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared types for the SDRAM controller front end: arbiter states and the
// per-port command payload muxed onto the controller interface.
package sdram_ctrl_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 16;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
      logic [SEL_W-1:0] sel;
      logic             we;
   } port_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt_c,
   output logic             valid_c
);

   int unsigned idx;

   always_comb begin
      gnt_c   = '0;
      valid_c = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!valid_c && req[idx]) begin
            gnt_c[idx] = 1'b1;
            valid_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter from N wb_port clients onto one SDRAM controller, with
// write reassembly broadcast on bufw_* to keep other ports' buffers coherent.
module wb_port_arbiter
   import sdram_ctrl_pkg::*;
#(
   parameter int unsigned WB_PORTS    = 2,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                   sdram_clk,
   input  logic                   sdram_rst_n,
   input  logic [32*WB_PORTS-1:0] port_adr_i,
   input  logic [16*WB_PORTS-1:0] port_dat_i,
   input  logic [2*WB_PORTS-1:0]  port_sel_i,
   input  logic [WB_PORTS-1:0]    port_acc_i,
   input  logic [WB_PORTS-1:0]    port_we_i,
   output logic [WB_PORTS-1:0]    port_ack_o,
   output logic [31:0]            port_adr_o,
   output logic [15:0]            port_dat_o,
   output logic [31:0]            adr_o,
   output logic [15:0]            dat_o,
   output logic [1:0]             sel_o,
   output logic                   acc_o,
   output logic                   we_o,
   input  logic [31:0]            adr_i,
   input  logic [15:0]            dat_i,
   input  logic                   ack_i,
   output logic [31:0]            bufw_adr_o,
   output logic [31:0]            bufw_dat_o,
   output logic [3:0]             bufw_sel_o,
   output logic                   bufw_we_o
);

   localparam int unsigned IDX_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [WB_PORTS-1:0] arb_gnt;
   logic                arb_valid;
   logic [IDX_W-1:0]    arb_idx;

   port_cmd_t cmd [WB_PORTS];
   port_cmd_t cmd_sel;
   logic      gacc;
   logic      wr_beat;
   logic      wr_ack;

   logic [15:0] up_dat_q;
   logic [1:0]  up_sel_q;

   rr_arbiter #(
      .N     (WB_PORTS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req     (port_acc_i),
      .ptr     (rr_ptr_q),
      .gnt_c   (arb_gnt),
      .valid_c (arb_valid)
   );

   // One-hot grant to index
   always_comb begin
      arb_idx = '0;
      for (int unsigned i = 0; i < WB_PORTS; i++) begin
         if (arb_gnt[i]) arb_idx = IDX_W'(i);
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
         cmd[p].adr = port_adr_i[32*p +: 32];
         cmd[p].dat = port_dat_i[16*p +: 16];
         cmd[p].sel = port_sel_i[2*p +: 2];
         cmd[p].we  = port_we_i[p];
      end
   end

   assign cmd_sel = grant_valid_q ? cmd[grant_q] : '0;
   assign gacc    = port_acc_i[grant_q];

   assign adr_o = cmd_sel.adr;
   assign dat_o = cmd_sel.dat;
   assign sel_o = cmd_sel.sel;
   assign we_o  = cmd_sel.we;
   assign acc_o = grant_valid_q && (state_q == GRANT) && gacc;

   assign port_adr_o = adr_i;
   assign port_dat_o = dat_i;

   // An ack with acc_o low belongs to nobody and is dropped
   always_comb begin
      port_ack_o = '0;
      if (acc_o && ack_i) port_ack_o[grant_q] = 1'b1;
   end

   assign wr_beat = acc_o && we_o && !ack_i;
   assign wr_ack  = acc_o && we_o && ack_i;

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   // HOLD keeps the grant across the gap between the two bursts of a refill
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      rr_ptr_d      = rr_ptr_q;
      hold_cnt_d    = hold_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d       = arb_idx;
               grant_valid_d = 1'b1;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (!gacc) begin
               state_d    = HOLD;
               hold_cnt_d = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         HOLD: begin
            if (gacc) begin
               state_d = GRANT;
            end else if (hold_cnt_q == '0) begin
               rr_ptr_d      = (grant_q == IDX_W'(WB_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Upper halfword is held until the acked lower beat completes the word
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         up_dat_q   <= '0;
         up_sel_q   <= '0;
         bufw_adr_o <= '0;
         bufw_dat_o <= '0;
         bufw_sel_o <= '0;
         bufw_we_o  <= 1'b0;
      end else begin
         bufw_we_o <= wr_ack;
         if (wr_beat) begin
            up_dat_q <= dat_o;
            up_sel_q <= sel_o;
         end
         if (wr_ack) begin
            bufw_adr_o <= {adr_o[31:2], 2'b00};
            bufw_dat_o <= {up_dat_q, dat_o};
            bufw_sel_o <= {up_sel_q, sel_o};
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (2 ports, 4 hold cycles).
module tb_wb_port_arbiter;

   logic        sdram_clk;
   logic        sdram_rst_n;
   logic [63:0] port_adr_i;
   logic [31:0] port_dat_i;
   logic [3:0]  port_sel_i;
   logic [1:0]  port_acc_i;
   logic [1:0]  port_we_i;
   logic [1:0]  port_ack_o;
   logic [31:0] port_adr_o;
   logic [15:0] port_dat_o;
   logic [31:0] adr_o;
   logic [15:0] dat_o;
   logic [1:0]  sel_o;
   logic        acc_o;
   logic        we_o;
   logic [31:0] adr_i;
   logic [15:0] dat_i;
   logic        ack_i;
   logic [31:0] bufw_adr_o;
   logic [31:0] bufw_dat_o;
   logic [3:0]  bufw_sel_o;
   logic        bufw_we_o;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(
      .WB_PORTS    (2),
      .HOLD_CYCLES (4)
   ) dut (
      .sdram_clk   (sdram_clk),
      .sdram_rst_n (sdram_rst_n),
      .port_adr_i  (port_adr_i),
      .port_dat_i  (port_dat_i),
      .port_sel_i  (port_sel_i),
      .port_acc_i  (port_acc_i),
      .port_we_i   (port_we_i),
      .port_ack_o  (port_ack_o),
      .port_adr_o  (port_adr_o),
      .port_dat_o  (port_dat_o),
      .adr_o       (adr_o),
      .dat_o       (dat_o),
      .sel_o       (sel_o),
      .acc_o       (acc_o),
      .we_o        (we_o),
      .adr_i       (adr_i),
      .dat_i       (dat_i),
      .ack_i       (ack_i),
      .bufw_adr_o  (bufw_adr_o),
      .bufw_dat_o  (bufw_dat_o),
      .bufw_sel_o  (bufw_sel_o),
      .bufw_we_o   (bufw_we_o)
   );

   initial sdram_clk = 1'b0;
   always #5 sdram_clk = ~sdram_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic acc, input logic we,
                           input logic [31:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel);
      port_acc_i[p]          = acc;
      port_we_i[p]           = we;
      port_adr_i[32*p +: 32] = adr;
      port_dat_i[16*p +: 16] = dat;
      port_sel_i[2*p +: 2]   = sel;
   endtask

   task automatic do_reset();
      sdram_rst_n = 1'b0;
      port_adr_i  = '0;
      port_dat_i  = '0;
      port_sel_i  = '0;
      port_acc_i  = '0;
      port_we_i   = '0;
      adr_i       = '0;
      dat_i       = '0;
      ack_i       = 1'b0;
      step();
      step();
      sdram_rst_n = 1'b1;
   endtask

   initial begin
      // Reset state: a requesting port must not leak through while in reset
      do_reset();
      sdram_rst_n = 1'b0;
      set_port(0, 1'b1, 1'b1, 32'h0000_1000, 16'hAABB, 2'b11);
      ack_i = 1'b1;
      #1;
      chk("rst_acc", acc_o, 1'b0);
      chk("rst_adr", adr_o, 32'h0);
      chk("rst_ack", port_ack_o, 2'b00);
      chk("rst_bufw_we", bufw_we_o, 1'b0);
      chk("rst_bufw_dat", bufw_dat_o, 32'h0);

      // Port 0 write: AABB beat unacked, then CCDD acked
      do_reset();
      set_port(0, 1'b1, 1'b1, 32'h0000_1000, 16'hAABB, 2'b11);
      step();
      chk("wr_acc", acc_o, 1'b1);
      chk("wr_adr", adr_o, 32'h0000_1000);
      chk("wr_dat0", dat_o, 16'hAABB);
      chk("wr_we", we_o, 1'b1);
      chk("wr_sel", sel_o, 2'b11);
      chk("wr_noack", port_ack_o, 2'b00);
      step();
      set_port(0, 1'b1, 1'b1, 32'h0000_1002, 16'hCCDD, 2'b11);
      ack_i = 1'b1;
      #1;
      chk("wr_ack", port_ack_o, 2'b01);
      chk("wr_bufw_pre", bufw_we_o, 1'b0);
      step();
      ack_i = 1'b0;
      port_acc_i[0] = 1'b0;
      chk("wr_bufw_we", bufw_we_o, 1'b1);
      chk("wr_bufw_adr", bufw_adr_o, 32'h0000_1000);
      chk("wr_bufw_dat", bufw_dat_o, 32'hAABB_CCDD);
      chk("wr_bufw_sel", bufw_sel_o, 4'hF);
      step();
      chk("wr_bufw_once", bufw_we_o, 1'b0);
      chk("wr_bufw_hold", bufw_dat_o, 32'hAABB_CCDD);

      // Tie from reset: port 0 first, then port 1, then port 0 again
      do_reset();
      set_port(0, 1'b1, 1'b0, 32'h0000_0100, 16'h0, 2'b11);
      set_port(1, 1'b1, 1'b0, 32'h0000_0200, 16'h0, 2'b11);
      step();
      chk("tie_first_adr", adr_o, 32'h0000_0100);
      ack_i = 1'b1;
      #1;
      chk("tie_first_ack", port_ack_o, 2'b01);
      ack_i = 1'b0;
      port_acc_i[0] = 1'b0;
      step();
      chk("tie_hold_acc", acc_o, 1'b0);
      chk("tie_hold_adr", adr_o, 32'h0000_0100);
      repeat (4) step();
      chk("tie_idle_adr", adr_o, 32'h0);
      step();
      chk("tie_second_adr", adr_o, 32'h0000_0200);
      chk("tie_second_acc", acc_o, 1'b1);
      ack_i = 1'b1;
      #1;
      chk("tie_second_ack", port_ack_o, 2'b10);
      ack_i = 1'b0;
      port_acc_i[0] = 1'b1;
      port_acc_i[1] = 1'b0;
      step();
      repeat (4) step();
      chk("tie_idle2_acc", acc_o, 1'b0);
      port_acc_i[1] = 1'b1;
      step();
      chk("tie_third_adr", adr_o, 32'h0000_0100);

      // Port 1 refill: 3-cycle gap keeps the grant despite port 0 waiting
      do_reset();
      set_port(1, 1'b1, 1'b0, 32'h0000_0300, 16'h0, 2'b11);
      step();
      chk("refill_adr", adr_o, 32'h0000_0300);
      port_acc_i[1] = 1'b0;
      set_port(0, 1'b1, 1'b0, 32'h0000_0100, 16'h0, 2'b11);
      ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("refill_gap_acc", acc_o, 1'b0);
         chk("refill_gap_ack", port_ack_o, 2'b00);
      end
      port_acc_i[1] = 1'b1;
      step();
      chk("refill_resume_adr", adr_o, 32'h0000_0300);
      chk("refill_resume_acc", acc_o, 1'b1);
      chk("refill_resume_ack", port_ack_o, 2'b10);
      ack_i = 1'b0;

      // Port 1 gap of 5 cycles: grant released, port 0 served first
      do_reset();
      set_port(1, 1'b1, 1'b0, 32'h0000_0300, 16'h0, 2'b11);
      step();
      port_acc_i[1] = 1'b0;
      set_port(0, 1'b1, 1'b0, 32'h0000_0100, 16'h0, 2'b11);
      repeat (5) step();
      chk("release_idle_acc", acc_o, 1'b0);
      chk("release_idle_adr", adr_o, 32'h0);
      port_acc_i[1] = 1'b1;
      step();
      chk("release_p0_adr", adr_o, 32'h0000_0100);
      ack_i = 1'b1;
      #1;
      chk("release_p0_ack", port_ack_o, 2'b01);
      ack_i = 1'b0;

      // Port 0 read burst of 16 acks: no coherent-write strobe
      do_reset();
      set_port(0, 1'b1, 1'b0, 32'h0000_0400, 16'h0, 2'b11);
      step();
      for (int k = 0; k < 16; k++) begin
         ack_i = 1'b1;
         dat_i = 16'h1000 + 16'(k);
         adr_i = 32'h0000_0400 + 32'(2 * k);
         #1;
         chk("rd_ack", port_ack_o, 2'b01);
         chk("rd_dat", port_dat_o, 16'h1000 + 16'(k));
         chk("rd_adr", port_adr_o, 32'h0000_0400 + 32'(2 * k));
         chk("rd_bufw_we", bufw_we_o, 1'b0);
         step();
      end
      ack_i = 1'b0;
      #1;
      chk("rd_bufw_after", bufw_we_o, 1'b0);

      // Reset mid-write: aborts at once, no strobe after release
      do_reset();
      set_port(0, 1'b1, 1'b1, 32'h0000_2000, 16'h1111, 2'b11);
      step();
      chk("abort_acc_pre", acc_o, 1'b1);
      step();
      #2;
      sdram_rst_n = 1'b0;
      ack_i = 1'b1;
      #1;
      chk("abort_acc", acc_o, 1'b0);
      chk("abort_ack", port_ack_o, 2'b00);
      ack_i = 1'b0;
      port_acc_i[0] = 1'b0;
      step();
      sdram_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_bufw_we", bufw_we_o, 1'b0);
         chk("abort_bufw_dat", bufw_dat_o, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
